// File: rtl/lstm_pkg.sv
// Shared LSTM definitions: fixed-point format, cell-update FSM encoding and
// the round-half-up / saturate helper used by every multiply-accumulate path.
// Latency: n/a (types and functions only). Backpressure: n/a.
package lstm_pkg;

  localparam int DATA_W = 16;            // signed Q4.12 gates and cell state
  localparam int FRAC   = 12;            // fraction bits, 1.0 = 4096
  localparam int ACC_W  = 2*DATA_W + 1;  // sum of two full-width products

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } cell_state_t;

  typedef struct packed {
    logic                     sat;
    logic signed [DATA_W-1:0] val;
  } rnd_sat_t;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DATA_W-1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;  // -(2^(DATA_W-1))

  // Round half-up at bit frac-1, shift back to DATA_W scale, clip to range.
  // The accumulator has headroom for the rounding add, so it cannot wrap.
  function automatic rnd_sat_t round_sat(input logic signed [ACC_W-1:0] s,
                                         input int                      frac);
    logic signed [ACC_W-1:0] r;
    rnd_sat_t                o;
    r     = (s + (ACC_W'(1) <<< (frac - 1))) >>> frac;
    o.sat = 1'b0;
    o.val = r[DATA_W-1:0];
    if (r > SAT_MAX) begin
      o.sat = 1'b1;
      o.val = SAT_MAX[DATA_W-1:0];
    end else if (r < SAT_MIN) begin
      o.sat = 1'b1;
      o.val = SAT_MIN[DATA_W-1:0];
    end
    return o;
  endfunction

endpackage

// File: rtl/lstm_cell_update_mac.sv
// Cell MAC: result = sat(round(f*c + i*g)); M stage registers both products, A stage sums/rounds/clips.
// Latency: fixed 2 cycles from i_vld to o_vld. Backpressure: none; i_flush drops everything in flight.
// Ports: clk/rst (sync, active-low); i_flush, i_vld, i_f/i_c/i_i/i_g in; o_m_vld, o_vld, o_res (held), o_sat out.
import lstm_pkg::*;

module cell_mac #(
  parameter int DATA_W = lstm_pkg::DATA_W,
  parameter int FRAC   = lstm_pkg::FRAC
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_flush,
  input  logic                     i_vld,
  input  logic signed [DATA_W-1:0] i_f,
  input  logic signed [DATA_W-1:0] i_c,
  input  logic signed [DATA_W-1:0] i_i,
  input  logic signed [DATA_W-1:0] i_g,
  output logic                     o_m_vld,
  output logic                     o_vld,
  output logic signed [DATA_W-1:0] o_res,
  output logic                     o_sat
);

  logic signed [2*DATA_W-1:0] r_p1;
  logic signed [2*DATA_W-1:0] r_p2;
  logic                       r_m_vld;
  logic                       r_a_vld;
  logic signed [DATA_W-1:0]   r_res;
  logic                       r_sat;
  logic signed [ACC_W-1:0]    w_sum;
  rnd_sat_t                   w_rs;

  assign w_sum = ACC_W'(r_p1) + ACC_W'(r_p2);
  assign w_rs  = round_sat(w_sum, FRAC);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_p1    <= '0;
      r_p2    <= '0;
      r_m_vld <= 1'b0;
      r_a_vld <= 1'b0;
      r_res   <= '0;
      r_sat   <= 1'b0;
    end else begin
      r_m_vld <= i_vld && !i_flush;
      r_a_vld <= r_m_vld && !i_flush;
      if (i_vld) begin
        r_p1 <= i_f * i_c;
        r_p2 <= i_i * i_g;
      end
      // Result is only updated by a real element so the write data holds between writes.
      if (r_m_vld && !i_flush) begin
        r_res <= w_rs.val;
        r_sat <= w_rs.sat;
      end
    end
  end

  assign o_m_vld = r_m_vld;
  assign o_vld   = r_a_vld;
  assign o_res   = r_res;
  assign o_sat   = r_sat;

endmodule

// File: rtl/lstm_cell_update.sv
// LSTM cell update: per gate beat reads c[t-1] from C BRAM, writes c[t] = sat(f*c + i*g) to the same address.
// Latency: beat accepted at T -> c_wr_en at T+RD_LAT+2; 1 element/cycle. Backpressure: gate_ready only in RUN.
// Ports: clk/rst (sync, active-low); start; gate_valid/gate_ready/gate_i/f/g; C BRAM rd/wr ports; busy, cell_done, sat_flag.
import lstm_pkg::*;

module lstm_cell_update #(
  parameter int DATA_W = lstm_pkg::DATA_W,
  parameter int FRAC   = lstm_pkg::FRAC,
  parameter int ADDR_W = 8,
  parameter int HIDDEN = 128,
  parameter int RD_LAT = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     gate_valid,
  output logic                     gate_ready,
  input  logic signed [DATA_W-1:0] gate_i,
  input  logic signed [DATA_W-1:0] gate_f,
  input  logic signed [DATA_W-1:0] gate_g,
  output logic                     c_rd_en,
  output logic        [ADDR_W-1:0] c_rd_addr,
  input  logic signed [DATA_W-1:0] c_rd_data,
  output logic                     c_wr_en,
  output logic        [ADDR_W-1:0] c_wr_addr,
  output logic signed [DATA_W-1:0] c_wr_data,
  output logic                     busy,
  output logic                     cell_done,
  output logic                     sat_flag
);

  typedef struct packed {
    logic [DATA_W-1:0] f;
    logic [DATA_W-1:0] i;
    logic [DATA_W-1:0] g;
    logic [ADDR_W-1:0] addr;
  } beat_t;

  cell_state_t              r_state;
  cell_state_t              w_state_nxt;
  logic [ADDR_W-1:0]        r_elem_cnt;
  logic [RD_LAT-1:0]        r_dl_vld;
  beat_t                    r_dl [RD_LAT];
  logic [ADDR_W-1:0]        r_addr_m;
  logic [ADDR_W-1:0]        r_wr_addr;
  logic                     r_sat_flag;
  logic                     w_take;
  logic                     w_last;
  logic                     w_m_vld;
  logic                     w_a_vld;
  logic                     w_a_sat;
  logic signed [DATA_W-1:0] w_a_res;

  // A beat offered in the same cycle as start belongs to the aborted pass and is dropped.
  assign w_take = gate_valid && (r_state == ST_RUN) && !start;
  assign w_last = (r_elem_cnt == ADDR_W'(HIDDEN - 1));

  always_ff @(posedge clk) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    gate_ready  = 1'b0;
    busy        = 1'b0;
    cell_done   = 1'b0;
    case (r_state)
      ST_IDLE: begin
      end
      ST_RUN: begin
        gate_ready = 1'b1;
        busy       = 1'b1;
        if (w_take && w_last) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        // Empty once the last element sits in stage A: its write happens this cycle.
        if (!(|r_dl_vld) && !w_m_vld) w_state_nxt = ST_DONE;
      end
      ST_DONE: cell_done = 1'b1;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (start) w_state_nxt = ST_RUN;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_dl_vld   <= '0;
      for (int k = 0; k < RD_LAT; k++) r_dl[k] <= '0;
      r_elem_cnt <= '0;
      r_addr_m   <= '0;
      r_wr_addr  <= '0;
      r_sat_flag <= 1'b0;
    end else begin
      r_dl_vld[0] <= w_take;
      if (w_take) r_dl[0] <= {gate_f, gate_i, gate_g, r_elem_cnt};
      for (int k = 1; k < RD_LAT; k++) begin
        r_dl_vld[k] <= r_dl_vld[k-1] && !start;
        r_dl[k]     <= r_dl[k-1];
      end
      // Holds at HIDDEN-1 on the last beat so HIDDEN = 2^ADDR_W never wraps.
      if (start)                 r_elem_cnt <= '0;
      else if (w_take && !w_last) r_elem_cnt <= r_elem_cnt + ADDR_W'(1);
      if (r_dl_vld[RD_LAT-1])    r_addr_m   <= r_dl[RD_LAT-1].addr;
      if (w_m_vld && !start)     r_wr_addr  <= r_addr_m;
      if (start)                 r_sat_flag <= 1'b0;
      else if (w_a_vld && w_a_sat) r_sat_flag <= 1'b1;
    end
  end

  cell_mac #(
    .DATA_W (DATA_W),
    .FRAC   (FRAC)
  ) u_mac (
    .clk     (clk),
    .rst     (rst),
    .i_flush (start),
    .i_vld   (r_dl_vld[RD_LAT-1]),
    .i_f     ($signed(r_dl[RD_LAT-1].f)),
    .i_c     (c_rd_data),
    .i_i     ($signed(r_dl[RD_LAT-1].i)),
    .i_g     ($signed(r_dl[RD_LAT-1].g)),
    .o_m_vld (w_m_vld),
    .o_vld   (w_a_vld),
    .o_res   (w_a_res),
    .o_sat   (w_a_sat)
  );

  assign c_rd_en   = w_take;
  assign c_rd_addr = r_elem_cnt;
  assign c_wr_en   = w_a_vld;
  assign c_wr_addr = r_wr_addr;
  assign c_wr_data = w_a_res;
  // Sticky flag rises together with the clipped write.
  assign sat_flag  = r_sat_flag || (w_a_vld && w_a_sat);

endmodule
